// File: rtl/mem_stage_if.sv
// Bundle of the EXU->MEM->WB handshake, SRAM read data and MEM->IDU forwarding signals.
// slave is the MEM stage itself; master is whatever surrounds it (EXU, WB, SRAM, IDU).
interface mem_stage_if;
    logic        EXU_to_MEM_valid;
    logic        MEM_allow_in;
    logic [31:0] EXU_pc_to_MEM;
    logic [31:0] EXU_inst_to_MEM;
    logic [31:0] EXU_result_to_MEM;
    logic [12:0] EXU_signals_pass_to_MEM;
    logic [31:0] data_sram_rdata;
    logic        WB_allow_in;
    logic        MEM_to_WB_valid;
    logic [31:0] MEM_pc_to_WB;
    logic [31:0] MEM_inst_to_WB;
    logic [31:0] MEM_final_result;
    logic [5:0]  MEM_signals_pass_to_WB;
    logic        MEM_to_IDU_gr_we;
    logic [4:0]  MEM_to_IDU_dest;
    logic        MEM_to_IDU_valid;
    logic [31:0] MEM_to_IDU_forward;

    modport slave (
        input  EXU_to_MEM_valid, EXU_pc_to_MEM, EXU_inst_to_MEM, EXU_result_to_MEM,
               EXU_signals_pass_to_MEM, data_sram_rdata, WB_allow_in,
        output MEM_allow_in, MEM_to_WB_valid, MEM_pc_to_WB, MEM_inst_to_WB,
               MEM_final_result, MEM_signals_pass_to_WB, MEM_to_IDU_gr_we,
               MEM_to_IDU_dest, MEM_to_IDU_valid, MEM_to_IDU_forward
    );

    modport master (
        output EXU_to_MEM_valid, EXU_pc_to_MEM, EXU_inst_to_MEM, EXU_result_to_MEM,
               EXU_signals_pass_to_MEM, data_sram_rdata, WB_allow_in,
        input  MEM_allow_in, MEM_to_WB_valid, MEM_pc_to_WB, MEM_inst_to_WB,
               MEM_final_result, MEM_signals_pass_to_WB, MEM_to_IDU_gr_we,
               MEM_to_IDU_dest, MEM_to_IDU_valid, MEM_to_IDU_forward
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EXU payload, extends load data from the data SRAM,
// and freezes SRAM read data while WB stalls so a stalled load keeps its value.
module mem_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic resetn,
    mem_stage_if.slave bus
);

    typedef enum logic {LIVE, HELD} hold_state_e;

    hold_state_e state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] result_q;
    logic [12:0] sig_q;
    logic [31:0] hold_q;

    logic        allow_in;
    logic        accept;
    logic        capture;
    logic [31:0] word_sel;
    logic [31:0] final_result;

    // sig_q layout: {res_from_mem[4:0], mem_offsets[1:0], gr_we, dest[4:0]}
    function automatic logic [31:0] load_extend(input logic [4:0]  rfm,
                                                input logic [1:0]  off,
                                                input logic [31:0] word,
                                                input logic [31:0] alu);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        if (rfm[0])      load_extend = word;
        else if (rfm[1]) load_extend = {{16{h[15]}}, h};
        else if (rfm[2]) load_extend = {16'h0000, h};
        else if (rfm[3]) load_extend = {{24{b[7]}}, b};
        else if (rfm[4]) load_extend = {24'h000000, b};
        else             load_extend = alu;
    endfunction

    assign allow_in = !valid_q || bus.WB_allow_in;
    assign accept   = allow_in && bus.EXU_to_MEM_valid;
    // The SRAM output moves on once EXU issues its next address, so freeze it on the first stalled edge.
    assign capture  = (state_q == LIVE) && valid_q && !bus.WB_allow_in;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        if (allow_in) valid_d = bus.EXU_to_MEM_valid;
        case (state_q)
            LIVE: if (capture) state_d = HELD;
            HELD: if (accept || (valid_q && bus.WB_allow_in)) state_d = LIVE;
            default: state_d = LIVE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= LIVE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q     <= RESET_PC;
            inst_q   <= 32'h0;
            result_q <= 32'h0;
            sig_q    <= 13'h0;
            hold_q   <= 32'h0;
        end else begin
            if (accept) begin
                pc_q     <= bus.EXU_pc_to_MEM;
                inst_q   <= bus.EXU_inst_to_MEM;
                result_q <= bus.EXU_result_to_MEM;
                sig_q    <= bus.EXU_signals_pass_to_MEM;
            end
            if (capture) hold_q <= bus.data_sram_rdata;
        end
    end

    assign word_sel     = (state_q == HELD) ? hold_q : bus.data_sram_rdata;
    assign final_result = load_extend(sig_q[12:8], sig_q[7:6], word_sel, result_q);

    assign bus.MEM_allow_in           = allow_in;
    assign bus.MEM_to_WB_valid        = valid_q;
    assign bus.MEM_pc_to_WB           = pc_q;
    assign bus.MEM_inst_to_WB         = inst_q;
    assign bus.MEM_final_result       = final_result;
    assign bus.MEM_signals_pass_to_WB = sig_q[5:0];
    assign bus.MEM_to_IDU_gr_we       = sig_q[5];
    assign bus.MEM_to_IDU_dest        = sig_q[4:0];
    assign bus.MEM_to_IDU_valid       = valid_q;
    assign bus.MEM_to_IDU_forward     = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: reset, pass-through, load extraction, stall hold,
// back-to-back flow and forwarding.
module tb_mem_stage;

    localparam logic [31:0] RST_PC = 32'h1C00_0000;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;

    mem_stage_if bus();

    mem_stage #(.RESET_PC(RST_PC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] res, input logic [12:0] sig);
        bus.EXU_to_MEM_valid        = v;
        bus.EXU_pc_to_MEM           = pc;
        bus.EXU_inst_to_MEM         = inst;
        bus.EXU_result_to_MEM       = res;
        bus.EXU_signals_pass_to_MEM = sig;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 13'h0);
        bus.data_sram_rdata = 32'h0;
        bus.WB_allow_in     = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (bus.MEM_pc_to_WB !== RST_PC) begin
            n_fail++; $display("FAIL reset_pc: got %h expected %h", bus.MEM_pc_to_WB, RST_PC);
        end
        resetn = 1'b1;
        tick();
        drive(1'b1, 32'h0000_0100, 32'h0, 32'h0000_0042, {5'b0, 2'b00, 1'b1, 5'd2});
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 13'h0);
        bus.WB_allow_in = 1'b0;
        #1;
        n_checks++;
        if (bus.MEM_to_WB_valid !== 1'b1 || bus.MEM_pc_to_WB !== 32'h0000_0100) begin
            n_fail++; $display("FAIL pre_reset_load: valid=%b pc=%h expected 1/00000100",
                               bus.MEM_to_WB_valid, bus.MEM_pc_to_WB);
        end
        #1;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (bus.MEM_to_WB_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_valid: got %b expected 0", bus.MEM_to_WB_valid);
        end
        n_checks++;
        if (bus.MEM_pc_to_WB !== RST_PC) begin
            n_fail++; $display("FAIL async_reset_pc: got %h expected %h", bus.MEM_pc_to_WB, RST_PC);
        end
        n_checks++;
        if (bus.MEM_final_result !== 32'h0 || bus.MEM_to_IDU_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_outputs: result=%h idu_valid=%b expected 0/0",
                               bus.MEM_final_result, bus.MEM_to_IDU_valid);
        end
        tick();
        resetn = 1'b1;
        bus.WB_allow_in = 1'b1;
        tick();
        n_checks++;
        if (bus.MEM_allow_in !== 1'b1 || bus.MEM_to_WB_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: allow_in=%b valid=%b expected 1/0",
                               bus.MEM_allow_in, bus.MEM_to_WB_valid);
        end
    endtask

    task automatic test_alu_pass();
        bus.WB_allow_in = 1'b1;
        drive(1'b1, 32'h0000_0200, 32'h0000_0011, 32'h1234_5678, {5'b0, 2'b00, 1'b1, 5'd7});
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 13'h0);
        #1;
        n_checks++;
        if (bus.MEM_final_result !== 32'h1234_5678) begin
            n_fail++; $display("FAIL alu_result: got %h expected 12345678", bus.MEM_final_result);
        end
        n_checks++;
        if (bus.MEM_signals_pass_to_WB !== 6'b1_00111) begin
            n_fail++; $display("FAIL alu_signals: got %b expected 100111", bus.MEM_signals_pass_to_WB);
        end
        n_checks++;
        if (bus.MEM_to_WB_valid !== 1'b1 || bus.MEM_pc_to_WB !== 32'h0000_0200 ||
            bus.MEM_inst_to_WB !== 32'h0000_0011) begin
            n_fail++; $display("FAIL alu_payload: valid=%b pc=%h inst=%h expected 1/00000200/00000011",
                               bus.MEM_to_WB_valid, bus.MEM_pc_to_WB, bus.MEM_inst_to_WB);
        end
        tick();
        n_checks++;
        if (bus.MEM_to_WB_valid !== 1'b0) begin
            n_fail++; $display("FAIL alu_one_cycle: valid=%b expected 0", bus.MEM_to_WB_valid);
        end
    endtask

    task automatic test_loads();
        logic [4:0]  rfm [8];
        logic [1:0]  off [8];
        logic [31:0] exp [8];
        rfm[0] = 5'b01000; off[0] = 2'd3; exp[0] = 32'hFFFF_FF80; // ld.b
        rfm[1] = 5'b10000; off[1] = 2'd3; exp[1] = 32'h0000_0080; // ld.bu
        rfm[2] = 5'b00010; off[2] = 2'd2; exp[2] = 32'hFFFF_80FF; // ld.h
        rfm[3] = 5'b00100; off[3] = 2'd0; exp[3] = 32'h0000_7F01; // ld.hu
        rfm[4] = 5'b00001; off[4] = 2'd0; exp[4] = 32'h80FF_7F01; // ld.w
        rfm[5] = 5'b01000; off[5] = 2'd1; exp[5] = 32'h0000_007F; // ld.b positive
        rfm[6] = 5'b01000; off[6] = 2'd2; exp[6] = 32'hFFFF_FFFF; // ld.b 0xFF
        rfm[7] = 5'b00010; off[7] = 2'd0; exp[7] = 32'h0000_7F01; // ld.h positive
        bus.WB_allow_in     = 1'b1;
        bus.data_sram_rdata = 32'h80FF_7F01;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h0000_1000 + 32'(i * 4), 32'h0, 32'hAAAA_5555,
                  {rfm[i], off[i], 1'b1, 5'd3});
            tick();
            drive(1'b0, 32'h0, 32'h0, 32'h0, 13'h0);
            #1;
            n_checks++;
            if (bus.MEM_final_result !== exp[i]) begin
                n_fail++; $display("FAIL load_%0d rfm=%b off=%0d: got %h expected %h",
                                   i, rfm[i], off[i], bus.MEM_final_result, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_stall_hold();
        bus.WB_allow_in     = 1'b0;
        bus.data_sram_rdata = 32'hDEAD_BEEF;
        drive(1'b1, 32'h0000_0300, 32'h0, 32'h0000_2000, {5'b00001, 2'b00, 1'b1, 5'd4});
        tick();
        // EXU keeps offering the next load while WB stalls.
        drive(1'b1, 32'h0000_0304, 32'h0, 32'h0000_2004, {5'b00001, 2'b00, 1'b1, 5'd6});
        #1;
        n_checks++;
        if (bus.MEM_final_result !== 32'hDEAD_BEEF || bus.MEM_allow_in !== 1'b0) begin
            n_fail++; $display("FAIL stall_first: result=%h allow_in=%b expected deadbeef/0",
                               bus.MEM_final_result, bus.MEM_allow_in);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            bus.data_sram_rdata = 32'h0;
            #1;
            n_checks++;
            if (bus.MEM_final_result !== 32'hDEAD_BEEF || bus.MEM_allow_in !== 1'b0 ||
                bus.MEM_pc_to_WB !== 32'h0000_0300) begin
                n_fail++; $display("FAIL stall_hold_%0d: result=%h allow_in=%b pc=%h expected deadbeef/0/00000300",
                                   c, bus.MEM_final_result, bus.MEM_allow_in, bus.MEM_pc_to_WB);
            end
        end
        bus.WB_allow_in = 1'b1;
        #1;
        n_checks++;
        if (bus.MEM_allow_in !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_allow: got %b expected 1", bus.MEM_allow_in);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 13'h0);
        bus.data_sram_rdata = 32'h1357_9BDF;
        #1;
        n_checks++;
        if (bus.MEM_final_result !== 32'h1357_9BDF || bus.MEM_pc_to_WB !== 32'h0000_0304) begin
            n_fail++; $display("FAIL stall_back_to_live: result=%h pc=%h expected 13579bdf/00000304",
                               bus.MEM_final_result, bus.MEM_pc_to_WB);
        end
        // Stall this load, then drain it with nothing new arriving.
        bus.WB_allow_in = 1'b0;
        tick();
        bus.data_sram_rdata = 32'h0;
        #1;
        n_checks++;
        if (bus.MEM_final_result !== 32'h1357_9BDF) begin
            n_fail++; $display("FAIL drain_hold: got %h expected 13579bdf", bus.MEM_final_result);
        end
        bus.WB_allow_in = 1'b1;
        tick();
        n_checks++;
        if (bus.MEM_to_WB_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_valid: got %b expected 0", bus.MEM_to_WB_valid);
        end
        drive(1'b1, 32'h0000_0308, 32'h0, 32'h0000_2008, {5'b00001, 2'b00, 1'b1, 5'd8});
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 13'h0);
        bus.data_sram_rdata = 32'h2468_ACE0;
        #1;
        n_checks++;
        if (bus.MEM_final_result !== 32'h2468_ACE0) begin
            n_fail++; $display("FAIL drain_live: got %h expected 2468ace0", bus.MEM_final_result);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.WB_allow_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0000_0400 + 32'(i * 4), 32'h0, 32'h0000_00A0 + 32'(i),
                  {5'b0, 2'b00, 1'b1, 5'(i + 1)});
            tick();
            #1;
            n_checks++;
            if (bus.MEM_to_WB_valid !== 1'b1 || bus.MEM_pc_to_WB !== 32'h0000_0400 + 32'(i * 4) ||
                bus.MEM_final_result !== 32'h0000_00A0 + 32'(i)) begin
                n_fail++; $display("FAIL b2b_%0d: valid=%b pc=%h result=%h expected 1/%h/%h",
                                   i, bus.MEM_to_WB_valid, bus.MEM_pc_to_WB, bus.MEM_final_result,
                                   32'h0000_0400 + 32'(i * 4), 32'h0000_00A0 + 32'(i));
            end
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 13'h0);
        tick();
        n_checks++;
        if (bus.MEM_to_WB_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end: valid=%b expected 0", bus.MEM_to_WB_valid);
        end
    endtask

    task automatic test_forward();
        bus.WB_allow_in     = 1'b1;
        bus.data_sram_rdata = 32'h12AB_3456;
        drive(1'b1, 32'h0000_0500, 32'h0, 32'h0000_3002, {5'b10000, 2'b10, 1'b1, 5'd5});
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 13'h0);
        #1;
        n_checks++;
        if (bus.MEM_to_IDU_valid !== 1'b1 || bus.MEM_to_IDU_dest !== 5'd5 ||
            bus.MEM_to_IDU_gr_we !== 1'b1) begin
            n_fail++; $display("FAIL fwd_ctrl: valid=%b dest=%0d gr_we=%b expected 1/5/1",
                               bus.MEM_to_IDU_valid, bus.MEM_to_IDU_dest, bus.MEM_to_IDU_gr_we);
        end
        n_checks++;
        if (bus.MEM_to_IDU_forward !== 32'h0000_00AB) begin
            n_fail++; $display("FAIL fwd_data: got %h expected 000000ab", bus.MEM_to_IDU_forward);
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_alu_pass();
        test_loads();
        test_stall_hold();
        test_back_to_back();
        test_forward();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage, between EXU and WB.
- Registers the EXU payload under a valid/allow_in handshake.
- Captures synchronous data-SRAM read data, extracts and sign/zero-extends load results, and produces the final writeback value.
- Drives the MEM-to-IDU forwarding/hazard interface and holds SRAM read data across WB stalls.

Parameters:
RESET_PC, 32'h0000_0000, reset value of the internal pc register (and so of MEM_pc_to_WB)

Ports:
clk  input  1  clock; all state updates on the rising edge
resetn  input  1  asynchronous, active-low reset
EXU_to_MEM_valid  input  1  EXU holds a valid, ready instruction
MEM_allow_in  output  1  MEM can accept a new instruction this cycle
EXU_pc_to_MEM  input  32  instruction PC
EXU_inst_to_MEM  input  32  instruction word
EXU_result_to_MEM  input  32  ALU or divider result; equals the memory address for loads and stores
EXU_signals_pass_to_MEM  input  13  {res_from_mem[4:0], mem_offsets[1:0], gr_we, dest[4:0]}
data_sram_rdata  input  32  SRAM read data; valid the cycle after the address was presented
WB_allow_in  input  1  WB can accept an instruction
MEM_to_WB_valid  output  1  valid instruction offered to WB
MEM_pc_to_WB  output  32  registered PC
MEM_inst_to_WB  output  32  registered instruction
MEM_final_result  output  32  load-extended data or passed-through result
MEM_signals_pass_to_WB  output  6  {gr_we, dest[4:0]}
MEM_to_IDU_gr_we  output  1  registered gr_we
MEM_to_IDU_dest  output  5  registered dest
MEM_to_IDU_valid  output  1  stage valid
MEM_to_IDU_forward  output  32  equals MEM_final_result

Behaviour:
- Reset (resetn low, asynchronous):
  - MEM_valid=0; pc register = RESET_PC; inst, result, signal and hold registers = 0; hold_valid=0.
  - Consequently MEM_to_WB_valid=0, MEM_to_IDU_valid=0, MEM_final_result=0 during reset.
- Handshake:
  - ready_go is constant 1.
  - MEM_allow_in = !MEM_valid || WB_allow_in.
  - MEM_to_WB_valid = MEM_valid.
  - On a clk edge with MEM_allow_in=1: MEM_valid <= EXU_to_MEM_valid.
  - Payload registers load only when MEM_allow_in && EXU_to_MEM_valid; otherwise they hold.
- res_from_mem encoding (one-hot; all zero = non-load):
  - bit0 ld.w; bit1 ld.h; bit2 ld.hu; bit3 ld.b; bit4 ld.bu.
  - More than one bit set is illegal and the result is don't-care.
- Read-data hold FSM, two states:
  - LIVE: MEM_final_result uses data_sram_rdata.
  - HELD: MEM_final_result uses the rdata_hold register.
  - LIVE -> HELD when MEM_valid && !WB_allow_in at a clk edge; rdata_hold <= data_sram_rdata at that edge.
  - HELD -> LIVE whenever a new instruction is accepted.
  - HELD -> LIVE also when MEM_valid && WB_allow_in && !EXU_to_MEM_valid, with MEM_valid then going 0.
  - Purpose: the SRAM output changes once EXU presents its next address, so stalled load data must be frozen.
- Load extraction (selected word = LIVE ? data_sram_rdata : rdata_hold; off = registered mem_offsets):
  - byte = word[8*off+7 : 8*off].
  - half = off[1] ? word[31:16] : word[15:0].
  - ld.w: word.
  - ld.b: sign-extend byte; ld.bu: zero-extend byte.
  - ld.h: sign-extend half; ld.hu: zero-extend half.
  - Non-load: MEM_final_result = registered EXU result.
- Output path: MEM_final_result is purely combinational from the registers and rdata, with no extra latency. Accept-to-WB latency is 1 cycle when WB_allow_in=1.
- Forwarding:
  - MEM_to_IDU_* are driven from the registers regardless of load type; load data is available for forwarding in the MEM cycle.
  - IDU qualifies them with MEM_to_IDU_valid.
- Simultaneous events:
  - A new accept and a hold capture in the same edge cannot occur, because allow_in=0 whenever a capture happens.
  - On a drain (WB_allow_in=1) coinciding with EXU_to_MEM_valid=1, the new payload loads and the FSM is forced to LIVE.
- Reset mid-stall: the FSM returns to LIVE, hold_valid=0 and MEM_valid=0 immediately, without waiting for a clock edge.
- Misaligned offsets for ld.w/ld.h are not checked (exceptions are out of scope); the extraction rule is applied as written.

Test Plan:
- Reset: resetn=0 asynchronously mid-cycle -> MEM_to_WB_valid=0 and MEM_pc_to_WB=RESET_PC within the same cycle; MEM_allow_in=1 after release.
- ALU pass-through: accept result=0x1234_5678, signals={5'b0, 2'b00, 1, 5'd7}, WB_allow_in=1 -> next cycle MEM_final_result=0x1234_5678, MEM_signals_pass_to_WB={1, 5'd7}, MEM_to_WB_valid=1 for exactly one cycle.
- Loads with rdata=0x80FF_7F01:
  - ld.b off=3 -> 0xFFFF_FF80; ld.bu off=3 -> 0x0000_0080.
  - ld.h off=2 -> 0xFFFF_80FF; ld.hu off=0 -> 0x0000_7F01; ld.w -> 0x80FF_7F01.
- Stall hold: ld.w with rdata=0xDEAD_BEEF, WB_allow_in=0 for 3 cycles while rdata changes to 0x0 -> MEM_final_result stays 0xDEAD_BEEF and MEM_allow_in=0 throughout; when WB_allow_in=1, the next instruction is accepted and the FSM returns to LIVE.
- Back-to-back: continuous EXU_to_MEM_valid with WB_allow_in=1 for 4 instructions -> each appears at MEM_to_WB one cycle later, with none dropped or duplicated.
- Forwarding: ld.bu in MEM (dest=5, gr_we=1, rdata byte=0xAB) -> MEM_to_IDU_valid=1, MEM_to_IDU_dest=5, MEM_to_IDU_forward=0x0000_00AB.
